// File: rtl/time_keeper_pkg.sv
// Shared mode encodings for the digital clock blocks, plus a
// compare-and-wrap increment used by the time-of-day counters.
package time_keeper_pkg;

  localparam logic [1:0] M1_TIME  = 2'd0;
  localparam logic [1:0] M1_DATE  = 2'd1;
  localparam logic [1:0] M1_TIMER = 2'd2;
  localparam logic [1:0] M1_ALARM = 2'd3;

  localparam logic [1:0] M2_TIME_G    = 2'd0;
  localparam logic [1:0] M2_TIME_HOUR = 2'd1;
  localparam logic [1:0] M2_TIME_MIN  = 2'd2;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Prescaler producing a one-cycle sec_tick every CLKS_PER_SEC clocks;
// hold parks the count at 0 so counting restarts a full second later.
module tick_gen #(
  parameter int CLKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic sec_tick
);

  localparam int CW = $clog2(CLKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (hold || count_q == LAST) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign sec_tick = (count_q == LAST) && !hold;

endmodule

// File: rtl/time_keeper.sv
// 24 h time-of-day counter with hour/min setting in TIME mode; emits
// registered min_tick/day_tick pulses only on counted rollovers.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode1,
  input  logic [1:0] mode2,
  input  logic       increase,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       min_tick,
  output logic       day_tick
);

  logic [4:0] hours_q, hours_d;
  logic [5:0] mins_q, mins_d, secs_q, secs_d;
  logic       min_tick_q, min_tick_d, day_tick_q, day_tick_d;
  logic       inc_prev_q;
  logic       set_hour, set_min, set_mode, inc_rise, sec_tick;

  assign set_hour = (mode1 == M1_TIME) && (mode2 == M2_TIME_HOUR);
  assign set_min  = (mode1 == M1_TIME) && (mode2 == M2_TIME_MIN);
  assign set_mode = set_hour || set_min;
  assign inc_rise = increase && !inc_prev_q;

  tick_gen #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .hold     (set_mode),
    .sec_tick (sec_tick)
  );

  always_comb begin
    hours_d    = hours_q;
    mins_d     = mins_q;
    secs_d     = secs_q;
    min_tick_d = 1'b0;
    day_tick_d = 1'b0;
    if (set_hour && inc_rise) begin
      hours_d = 5'(inc_wrap({1'b0, hours_q}, {1'b0, HOUR_MAX}));
    end else if (set_min && inc_rise) begin
      mins_d = inc_wrap(mins_q, MIN_MAX);
      secs_d = 6'd0;
    end else if (sec_tick) begin
      // Carry chain: each stage advances only when the one below wraps.
      secs_d = inc_wrap(secs_q, SEC_MAX);
      if (secs_q == SEC_MAX) begin
        mins_d     = inc_wrap(mins_q, MIN_MAX);
        min_tick_d = 1'b1;
        if (mins_q == MIN_MAX) begin
          hours_d = 5'(inc_wrap({1'b0, hours_q}, {1'b0, HOUR_MAX}));
          if (hours_q == HOUR_MAX) day_tick_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hours_q    <= '0;
      mins_q     <= '0;
      secs_q     <= '0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      inc_prev_q <= 1'b0;
    end else begin
      hours_q    <= hours_d;
      mins_q     <= mins_d;
      secs_q     <= secs_d;
      min_tick_q <= min_tick_d;
      day_tick_q <= day_tick_d;
      inc_prev_q <= increase;
    end
  end

  assign hours    = hours_q;
  assign mins     = mins_q;
  assign secs     = secs_q;
  assign min_tick = min_tick_q;
  assign day_tick = day_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: seconds-of-day reference model checked every cycle,
// directed scenarios with literal expectations, then randomized modes/presses.
module tb_time_keeper;
  import time_keeper_pkg::*;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode1 = M1_TIME;
  logic [1:0] mode2 = M2_TIME_HOUR;
  logic       increase = 1'b1;
  logic [4:0] hours;
  logic [5:0] mins, secs;
  logic       min_tick, day_tick;

  time_keeper #(.CLKS_PER_SEC(C)) dut (
    .clk(clk), .reset(reset), .mode1(mode1), .mode2(mode2), .increase(increase),
    .hours(hours), .mins(mins), .secs(secs), .min_tick(min_tick), .day_tick(day_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: time as seconds-of-day, plus running cycles since last (re)start.
  int tod = 0;
  int run = 0;
  bit prev_inc = 1'b0;
  bit exp_min = 1'b0, exp_day = 1'b0;
  bit m_set_h, m_set_m, m_rise;

  int min_pulses = 0, day_pulses = 0, both_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    exp_min = 1'b0;
    exp_day = 1'b0;
    if (reset) begin
      tod = 0; run = 0; prev_inc = 1'b0;
    end else begin
      m_set_h = (mode1 == M1_TIME) && (mode2 == M2_TIME_HOUR);
      m_set_m = (mode1 == M1_TIME) && (mode2 == M2_TIME_MIN);
      m_rise  = increase && !prev_inc;
      prev_inc = increase;
      if (m_set_h || m_set_m) begin
        run = 0;
        if (m_rise && m_set_h) tod = (tod + 3600) % 86400;
        else if (m_rise) tod = (tod / 3600) * 3600 + ((((tod / 60) % 60) + 1) % 60) * 60;
      end else begin
        run++;
        if (run == C) begin
          run = 0;
          tod = (tod + 1) % 86400;
          exp_min = (tod % 60) == 0;
          exp_day = (tod == 0);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("hours",    int'(hours),    tod / 3600);
    check("mins",     int'(mins),     (tod / 60) % 60);
    check("secs",     int'(secs),     tod % 60);
    check("min_tick", int'(min_tick), int'(exp_min));
    check("day_tick", int'(day_tick), int'(exp_day));
    if (min_tick === 1'b1) min_pulses++;
    if (day_tick === 1'b1) day_pulses++;
    if (min_tick === 1'b1 && day_tick === 1'b1) both_pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; increase = 1'b0;
    cyc(1);
    reset = 1'b0;
    min_pulses = 0; day_pulses = 0; both_pulses = 0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      increase = 1'b1; cyc(1);
      increase = 1'b0; cyc(1);
    end
  endtask

  initial begin
    // 1: reset held two clocks while pressing in HOUR set
    cyc(2);
    check("t1_hours", int'(hours), 0);
    check("t1_mins",  int'(mins),  0);
    check("t1_secs",  int'(secs),  0);
    check("t1_ticks", int'(min_tick) + int'(day_tick), 0);
    increase = 1'b0;
    reset = 1'b0;

    // 2: free-run one minute
    do_reset();
    mode1 = M1_TIME; mode2 = M2_TIME_G;
    cyc(240);
    check("t2_hours", int'(hours), 0);
    check("t2_mins",  int'(mins),  1);
    check("t2_secs",  int'(secs),  0);
    check("t2_min_pulses", min_pulses, 1);
    check("t2_day_pulses", day_pulses, 0);

    // 3: 26 hour presses
    do_reset();
    mode2 = M2_TIME_HOUR;
    for (int i = 0; i < 26; i++) begin
      pulses(1);
      check("t3_hours", int'(hours), (i + 1) % 24);
    end
    check("t3_mins", int'(mins), 0);

    // 4: set 23:59 and roll over the day
    pulses(21);
    mode2 = M2_TIME_MIN;
    pulses(59);
    check("t4_set_hours", int'(hours), 23);
    check("t4_set_mins",  int'(mins),  59);
    mode2 = M2_TIME_G;
    min_pulses = 0; day_pulses = 0; both_pulses = 0;
    cyc(240);
    check("t4_hours", int'(hours), 0);
    check("t4_mins",  int'(mins),  0);
    check("t4_secs",  int'(secs),  0);
    check("t4_day_pulses",  day_pulses,  1);
    check("t4_min_pulses",  min_pulses,  1);
    check("t4_same_cycle",  both_pulses, 1);

    // 5: held press in MIN set gives one step; prescaler frozen
    cyc(6);
    mode2 = M2_TIME_MIN;
    increase = 1'b1; cyc(10);
    increase = 1'b0; cyc(1);
    check("t5_mins", int'(mins), 1);
    check("t5_secs", int'(secs), 0);
    mode2 = M2_TIME_G;
    cyc(3);
    check("t5_secs_hold", int'(secs), 0);
    cyc(1);
    check("t5_secs_first", int'(secs), 1);

    // 6: alarm mode ignores presses; reset mid-count
    do_reset();
    mode1 = M1_ALARM;
    for (int i = 0; i < 8; i++) begin
      increase = ~increase; cyc(1);
    end
    check("t6_secs",  int'(secs),  2);
    check("t6_hours", int'(hours), 0);
    check("t6_mins",  int'(mins),  0);
    cyc(5);
    reset = 1'b1; cyc(1);
    check("t6_rst_secs", int'(secs), 0);
    check("t6_rst_all",  int'(hours) + int'(mins) + int'(min_tick) + int'(day_tick), 0);
    reset = 1'b0;

    // Randomized mode changes, presses and occasional reset
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode1 = 2'($urandom_range(0, 3));
        mode2 = 2'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) == 0) increase = ~increase;
      reset = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
